// File: rtl/arbitro_memoria_dados.sv
// ============================================================================
// Module  : arbitro_memoria_dados
// Purpose : Two-port round-robin arbiter/sequencer for a single-port data memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_memoria_dados #(
    parameter int LARGURA_END     = 8,
    parameter int LARGURA_DADO    = 8,
    parameter int PRIORIDADE_FIXA = 0
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    ReqA,
    input  logic                    EscA,
    input  logic [LARGURA_END-1:0]  EndA,
    input  logic [LARGURA_DADO-1:0] DadoA,
    output logic                    AckA,
    input  logic                    ReqB,
    input  logic                    EscB,
    input  logic [LARGURA_END-1:0]  EndB,
    input  logic [LARGURA_DADO-1:0] DadoB,
    output logic                    AckB,
    output logic [LARGURA_DADO-1:0] DadoSaida,
    output logic                    Ocupado,
    output logic                    EscMem,
    output logic                    LerMem,
    output logic [LARGURA_END-1:0]  Endereco,
    output logic [LARGURA_DADO-1:0] DadoEscritoMem,
    input  logic [LARGURA_DADO-1:0] DadoLido
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ACESSO   = 2'd1,
        RESPOSTA = 2'd2
    } estado_t;

    estado_t                 estado, prox_estado;
    logic                    ultimo_b, prox_ultimo_b;
    logic                    vencedor_b, prox_vencedor_b;
    logic                    prox_ack_a, prox_ack_b;
    logic                    prox_esc_mem, prox_ler_mem;
    logic                    prox_ocupado;
    logic [LARGURA_END-1:0]  prox_endereco;
    logic [LARGURA_DADO-1:0] prox_dado_escrito;
    logic [LARGURA_DADO-1:0] prox_dado_saida;
    logic                    escolhe_b;
    logic                    esc_vencedor;

    // B wins when it is alone, or on a tie when round-robin says it is B's turn.
    assign escolhe_b    = ReqB && (!ReqA || ((PRIORIDADE_FIXA == 0) && !ultimo_b));
    assign esc_vencedor = escolhe_b ? EscB : EscA;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            estado         <= OCIOSO;
            ultimo_b       <= 1'b1;
            vencedor_b     <= 1'b0;
            AckA           <= 1'b0;
            AckB           <= 1'b0;
            EscMem         <= 1'b0;
            LerMem         <= 1'b0;
            Ocupado        <= 1'b0;
            Endereco       <= '0;
            DadoEscritoMem <= '0;
            DadoSaida      <= '0;
        end else begin
            estado         <= prox_estado;
            ultimo_b       <= prox_ultimo_b;
            vencedor_b     <= prox_vencedor_b;
            AckA           <= prox_ack_a;
            AckB           <= prox_ack_b;
            EscMem         <= prox_esc_mem;
            LerMem         <= prox_ler_mem;
            Ocupado        <= prox_ocupado;
            Endereco       <= prox_endereco;
            DadoEscritoMem <= prox_dado_escrito;
            DadoSaida      <= prox_dado_saida;
        end
    end

    always_comb begin
        prox_estado       = estado;
        prox_ultimo_b     = ultimo_b;
        prox_vencedor_b   = vencedor_b;
        prox_ack_a        = 1'b0;
        prox_ack_b        = 1'b0;
        prox_esc_mem      = 1'b0;
        prox_ler_mem      = 1'b0;
        prox_endereco     = Endereco;
        prox_dado_escrito = DadoEscritoMem;
        prox_dado_saida   = DadoSaida;

        case (estado)
            OCIOSO: begin
                if (ReqA || ReqB) begin
                    prox_vencedor_b   = escolhe_b;
                    prox_endereco     = escolhe_b ? EndB : EndA;
                    prox_dado_escrito = escolhe_b ? DadoB : DadoA;
                    prox_esc_mem      = esc_vencedor;
                    prox_ler_mem      = !esc_vencedor;
                    prox_estado       = ACESSO;
                end
            end
            ACESSO: begin
                // Memory drove DadoLido at the mid-cycle negedge.
                if (LerMem) begin
                    prox_dado_saida = DadoLido;
                end
                prox_ack_a    = !vencedor_b;
                prox_ack_b    = vencedor_b;
                prox_ultimo_b = vencedor_b;
                prox_estado   = RESPOSTA;
            end
            RESPOSTA: begin
                prox_estado = OCIOSO;
            end
            default: begin
                prox_estado = OCIOSO;
            end
        endcase

        prox_ocupado = (prox_estado != OCIOSO);
    end

endmodule

`default_nettype wire

// File: tb/tb_arbitro_memoria_dados.sv
// ============================================================================
// Module  : tb_arbitro_memoria_dados
// Purpose : Scoreboard bench for arbitro_memoria_dados (round-robin and fixed).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arbitro_memoria_dados;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       ReqA = 1'b0, EscA = 1'b0, ReqB = 1'b0, EscB = 1'b0;
    logic [7:0] EndA = '0, DadoA = '0, EndB = '0, DadoB = '0;

    logic       ack_a0, ack_b0, ocup0, esc0, ler0;
    logic [7:0] saida0, end0, dw0, lido0;
    logic       ack_a1, ack_b1, ocup1, esc1, ler1;
    logic [7:0] saida1, end1, dw1, lido1;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] ref_mem [256];

    typedef struct packed {
        logic       is_b;
        logic       rd;
        logic [7:0] data;
    } esp_t;

    esp_t q0[$];
    esp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    always #5 Clock = ~Clock;

    arbitro_memoria_dados #(.LARGURA_END(8), .LARGURA_DADO(8), .PRIORIDADE_FIXA(0)) dut0 (
        .Clock(Clock), .Reset(Reset),
        .ReqA(ReqA), .EscA(EscA), .EndA(EndA), .DadoA(DadoA), .AckA(ack_a0),
        .ReqB(ReqB), .EscB(EscB), .EndB(EndB), .DadoB(DadoB), .AckB(ack_b0),
        .DadoSaida(saida0), .Ocupado(ocup0), .EscMem(esc0), .LerMem(ler0),
        .Endereco(end0), .DadoEscritoMem(dw0), .DadoLido(lido0)
    );

    arbitro_memoria_dados #(.LARGURA_END(8), .LARGURA_DADO(8), .PRIORIDADE_FIXA(1)) dut1 (
        .Clock(Clock), .Reset(Reset),
        .ReqA(ReqA), .EscA(EscA), .EndA(EndA), .DadoA(DadoA), .AckA(ack_a1),
        .ReqB(ReqB), .EscB(EscB), .EndB(EndB), .DadoB(DadoB), .AckB(ack_b1),
        .DadoSaida(saida1), .Ocupado(ocup1), .EscMem(esc1), .LerMem(ler1),
        .Endereco(end1), .DadoEscritoMem(dw1), .DadoLido(lido1)
    );

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory models: write at posedge, read at negedge.
    always @(posedge Clock) begin
        if (esc0) mem0[end0] = dw0;
        if (esc1) mem1[end1] = dw1;
    end

    always @(negedge Clock) begin
        if (ler0) lido0 = mem0[end0];
        if (ler1) lido1 = mem1[end1];
    end

    // Invariants every cycle and scoreboard pop on each Ack.
    always @(negedge Clock) begin
        esp_t e;
        verifica("inv_strb0", 32'(esc0 & ler0), 0);
        verifica("inv_ack0", 32'(ack_a0 & ack_b0), 0);
        verifica("inv_strb_ocup0", 32'((esc0 | ler0) & ~ocup0), 0);
        verifica("inv_strb1", 32'(esc1 & ler1), 0);
        verifica("inv_ack1", 32'(ack_a1 & ack_b1), 0);
        verifica("inv_strb_ocup1", 32'((esc1 | ler1) & ~ocup1), 0);
        if (ack_a0 | ack_b0) begin
            if (q0.size() == 0) begin
                verifica("ack0_unexpected", 1, 0);
            end else begin
                e = q0.pop_front();
                verifica("ack0_port", 32'(ack_b0), 32'(e.is_b));
                if (e.rd) verifica("ack0_data", 32'(saida0), 32'(e.data));
            end
        end
        if (ack_a1 | ack_b1) begin
            if (q1.size() == 0) begin
                verifica("ack1_unexpected", 1, 0);
            end else begin
                e = q1.pop_front();
                verifica("ack1_port", 32'(ack_b1), 32'(e.is_b));
                if (e.rd) verifica("ack1_data", 32'(saida1), 32'(e.data));
            end
        end
    end

    function automatic esp_t espera(input logic b, input logic esc, input logic [7:0] addr,
                                    input logic [7:0] dat);
        esp_t e;
        e.is_b = b;
        e.rd   = ~esc;
        e.data = esc ? dat : ref_mem[addr];
        return e;
    endfunction

    task automatic do_reset();
        Reset = 1'b1;
        ReqA  = 1'b0;
        ReqB  = 1'b0;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
    endtask

    task automatic run_access(input logic b, input logic esc, input logic [7:0] addr,
                              input logic [7:0] dat);
        int n_str = 0, t_str = -1, t_ack = -1, n_ocup = 0, n_other = 0, n_wrong = 0;
        esp_t e;
        @(posedge Clock);
        #1;
        if (b) begin
            ReqB = 1'b1; EscB = esc; EndB = addr; DadoB = dat;
        end else begin
            ReqA = 1'b1; EscA = esc; EndA = addr; DadoA = dat;
        end
        e = espera(b, esc, addr, dat);
        q0.push_back(e);
        q1.push_back(e);
        if (esc) ref_mem[addr] = dat;
        for (int i = 1; i <= 7; i++) begin
            @(negedge Clock);
            if (esc ? esc0 : ler0) begin
                n_str++;
                t_str = i;
                verifica("acc_endereco", 32'(end0), 32'(addr));
                if (esc) verifica("acc_dado_esc", 32'(dw0), 32'(dat));
            end
            if (esc ? ler0 : esc0) n_wrong++;
            if (ocup0) n_ocup++;
            if (b ? ack_b0 : ack_a0) begin
                t_ack = i;
                ReqA  = 1'b0;
                ReqB  = 1'b0;
            end
            if (b ? ack_a0 : ack_b0) n_other++;
        end
        ReqA = 1'b0;
        ReqB = 1'b0;
        verifica("acc_n_strobe", 32'(n_str), 1);
        verifica("acc_t_strobe", 32'(t_str), 2);
        verifica("acc_t_ack", 32'(t_ack), 3);
        verifica("acc_n_ocupado", 32'(n_ocup), 2);
        verifica("acc_other_ack", 32'(n_other), 0);
        verifica("acc_wrong_strobe", 32'(n_wrong), 0);
    endtask

    initial begin
        int t_ler [2];
        int t0 [5];
        int t1 [5];
        int n0, n1, n_ler, n_esc, n_ack;

        for (int i = 0; i < 256; i++) begin
            mem0[i]    = 8'(i) ^ 8'hC3;
            mem1[i]    = 8'(i) ^ 8'hC3;
            ref_mem[i] = 8'(i) ^ 8'hC3;
        end

        // Reset state
        do_reset();
        @(negedge Clock);
        verifica("reset_outputs",
                 32'({ack_a0, ack_b0, saida0, ocup0, esc0, ler0, end0, dw0}), 0);
        verifica("reset_outputs_fixa",
                 32'({ack_a1, ack_b1, saida1, ocup1, esc1, ler1, end1, dw1}), 0);

        // Single-requester accesses through both ports
        run_access(1'b0, 1'b1, 8'h10, 8'h5A);
        run_access(1'b0, 1'b0, 8'h10, 8'h00);
        run_access(1'b1, 1'b1, 8'h33, 8'hA5);
        run_access(1'b1, 1'b0, 8'h33, 8'h00);
        run_access(1'b1, 1'b0, 8'h10, 8'h00);

        // ReqA held past AckA: second access starts 3 cycles after the first
        @(posedge Clock);
        #1 ReqA = 1'b1; EscA = 1'b0; EndA = 8'h10;
        repeat (2) begin
            q0.push_back(espera(1'b0, 1'b0, 8'h10, 8'h00));
            q1.push_back(espera(1'b0, 1'b0, 8'h10, 8'h00));
        end
        n_ler = 0;
        n_ack = 0;
        for (int i = 1; i <= 12 && n_ack < 2; i++) begin
            @(negedge Clock);
            if (ler0) begin
                if (n_ler < 2) t_ler[n_ler] = i;
                n_ler++;
            end
            if (ack_a0) begin
                n_ack++;
                if (n_ack == 2) ReqA = 1'b0;
            end
        end
        ReqA = 1'b0;
        verifica("held_n_ack", 32'(n_ack), 2);
        verifica("held_n_ler", 32'(n_ler), 2);
        verifica("held_gap", 32'(t_ler[1] - t_ler[0]), 3);

        // Both requesters held: round-robin on dut0, A-priority on dut1
        do_reset();
        @(posedge Clock);
        #1;
        ReqA = 1'b1; EscA = 1'b0; EndA = 8'h01;
        ReqB = 1'b1; EscB = 1'b0; EndB = 8'h02;
        for (int k = 0; k < 4; k++) begin
            q0.push_back(espera(1'(k % 2), 1'b0, (k % 2 == 1) ? 8'h02 : 8'h01, 8'h00));
            q1.push_back(espera(1'b0, 1'b0, 8'h01, 8'h00));
        end
        q0.push_back(espera(1'b1, 1'b0, 8'h02, 8'h00));
        q1.push_back(espera(1'b1, 1'b0, 8'h02, 8'h00));
        n0 = 0;
        n1 = 0;
        n_esc = 0;
        for (int i = 1; i <= 40 && (n0 < 5 || n1 < 5); i++) begin
            @(negedge Clock);
            if (esc0 | esc1) n_esc++;
            if ((ack_a0 | ack_b0) && n0 < 5) begin
                t0[n0] = i;
                n0++;
            end
            if ((ack_a1 | ack_b1) && n1 < 5) begin
                t1[n1] = i;
                n1++;
            end
            if (n0 == 4) ReqA = 1'b0;
        end
        ReqA = 1'b0;
        ReqB = 1'b0;
        verifica("rr_n_ack0", 32'(n0), 5);
        verifica("rr_n_ack1", 32'(n1), 5);
        verifica("rr_no_write", 32'(n_esc), 0);
        for (int k = 1; k < 5; k++) begin
            verifica("rr_period0", 32'(t0[k] - t0[k-1]), 3);
            verifica("rr_period1", 32'(t1[k] - t1[k-1]), 3);
        end

        // Reset during the ACESSO cycle of a B write
        do_reset();
        @(posedge Clock);
        #1 ReqB = 1'b1; EscB = 1'b1; EndB = 8'h20; DadoB = 8'hFF;
        @(posedge Clock);
        #2;
        verifica("abort_esc_before", 32'(esc0), 1);
        Reset = 1'b1;
        #1;
        verifica("abort_esc_after", 32'(esc0), 0);
        verifica("abort_ocupado", 32'(ocup0), 0);
        ReqB = 1'b0;
        n_ack = 0;
        repeat (3) begin
            @(negedge Clock);
            if (ack_b0 | ack_b1) n_ack++;
        end
        #1 Reset = 1'b0;
        repeat (3) begin
            @(negedge Clock);
            if (ack_b0 | ack_b1) n_ack++;
        end
        verifica("abort_no_ackb", 32'(n_ack), 0);
        run_access(1'b0, 1'b0, 8'h20, 8'h00);

        repeat (3) @(negedge Clock);
        verifica("sb_empty0", 32'(q0.size()), 0);
        verifica("sb_empty1", 32'(q1.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
